mips_fetch_unit: RTL and testbench

- Instruction-fetch stage of the MIPS soft processor; holds the PC and fetches one instruction word at a time over a req/ack handshake from instruction memory.
- Presents the fetched word and its op-code slice to the main control unit.
- Computes the next PC from the is_jump/is_branch decode outputs and the ALU zero flag when downstream retires the instruction.
- Single-issue and non-pipelined: one instruction in flight.

---
 rtl/mips_fetch_unit.sv | 121 ++++++++++++
 tb/tb_mips_fetch_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one word over req/ack and computes the next PC.
// Optional performance counters are compiled in when MIPS_FETCH_PERF_EN is defined.
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned PERF_CNT_WIDTH = 32
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_instr,
  output logic [5:0]  o_op_code,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  input  logic        i_retire,
  input  logic        i_is_jump,
  input  logic        i_is_branch,
  input  logic        i_alu_zero
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] o_retired_cnt,
  output logic [PERF_CNT_WIDTH-1:0] o_stall_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_imem_req;

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;

  // Jump wins over branch when decode raises both.
  always_comb begin
    w_pc4    = r_pc + 32'd4;
    w_br_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
    if (i_is_jump) begin
      w_next_pc = {w_pc4[31:28], r_instr[25:0], 2'b00};
    end else if (i_is_branch && i_alu_zero) begin
      w_next_pc = w_pc4 + w_br_off;
    end else begin
      w_next_pc = w_pc4;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_REQ;
          r_imem_req <= 1'b1;
        end
        S_REQ: begin
          if (i_imem_ack) begin
            r_state       <= S_VALID;
            r_instr       <= i_imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
          end
        end
        S_VALID: begin
          if (i_retire) begin
            r_state       <= S_REQ;
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_valid <= 1'b0;
          r_imem_req    <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_instr       = r_instr;
  assign o_op_code     = r_instr[31:26];
  assign o_instr_valid = r_instr_valid;

`ifdef MIPS_FETCH_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] r_retired_cnt;
  logic [PERF_CNT_WIDTH-1:0] r_stall_cnt;

  // Both counters wrap silently at their maximum.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (r_state == S_VALID && i_retire) begin
        r_retired_cnt <= r_retired_cnt + PERF_CNT_WIDTH'(1);
      end
      if (r_state == S_REQ && !i_imem_ack) begin
        r_stall_cnt <= r_stall_cnt + PERF_CNT_WIDTH'(1);
      end
    end
  end

  assign o_retired_cnt = r_retired_cnt;
  assign o_stall_cnt   = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: expected fetch addresses are queued when a retire is
// driven and compared when the next request appears. Define MIPS_FETCH_PERF_EN to check counters.
module tb_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        i_clk;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_instr;
  logic [5:0]  o_op_code;
  logic        o_instr_valid;
  logic [31:0] o_pc;
  logic        i_retire;
  logic        i_is_jump;
  logic        i_is_branch;
  logic        i_alu_zero;
`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] o_retired_cnt;
  logic [31:0] o_stall_cnt;
`endif

  mips_fetch_unit #(
    .RESET_PC       (RESET_PC),
    .PERF_CNT_WIDTH (32)
  ) u_dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ack    (i_imem_ack),
    .i_imem_rdata  (i_imem_rdata),
    .o_instr       (o_instr),
    .o_op_code     (o_op_code),
    .o_instr_valid (o_instr_valid),
    .o_pc          (o_pc),
    .i_retire      (i_retire),
    .i_is_jump     (i_is_jump),
    .i_is_branch   (i_is_branch),
    .i_alu_zero    (i_alu_zero)
`ifdef MIPS_FETCH_PERF_EN
    ,
    .o_retired_cnt (o_retired_cnt),
    .o_stall_cnt   (o_stall_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] m_instr;
  int unsigned m_stall;
  int unsigned m_retired;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge; all driving and sampling happens there.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
`ifdef MIPS_FETCH_PERF_EN
    check({tag, "_retired_cnt"}, o_retired_cnt, m_retired);
    check({tag, "_stall_cnt"}, o_stall_cnt, m_stall);
`else
    if (tag.len() == 0) $display("counters disabled");
`endif
  endtask

  task automatic fetch(input logic [31:0] rdata, input int delay);
    logic [31:0] exp_addr;
    int          n;
    n = 0;
    while (!o_imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", {31'b0, o_imem_req}, 32'd1);
    if (exp_addr_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      exp_addr = 32'hxxxx_xxxx;
    end else begin
      exp_addr = exp_addr_q.pop_front();
    end
    check("imem_addr", o_imem_addr, exp_addr);
    check("valid_in_req", {31'b0, o_instr_valid}, 32'd0);
    for (int i = 0; i < delay; i++) begin
      tick();
      m_stall++;
      check("req_held", {31'b0, o_imem_req}, 32'd1);
      check("addr_stable", o_imem_addr, exp_addr);
    end
    i_imem_ack   = 1'b1;
    i_imem_rdata = rdata;
    tick();
    i_imem_ack   = 1'b0;
    i_imem_rdata = $urandom;
    m_instr      = rdata;
    check("valid_after_ack", {31'b0, o_instr_valid}, 32'd1);
    check("req_dropped", {31'b0, o_imem_req}, 32'd0);
    check("instr", o_instr, rdata);
    check("op_code", {26'b0, o_op_code}, {26'b0, rdata[31:26]});
    check("pc_of_instr", o_pc, exp_addr);
  endtask

  task automatic retire(input logic jmp, input logic br, input logic zero,
                        input logic [31:0] exp_next);
    exp_addr_q.push_back(exp_next);
    i_retire    = 1'b1;
    i_is_jump   = jmp;
    i_is_branch = br;
    i_alu_zero  = zero;
    tick();
    m_retired++;
    i_retire    = 1'b0;
    i_is_jump   = $urandom_range(0, 1);
    i_is_branch = $urandom_range(0, 1);
    i_alu_zero  = $urandom_range(0, 1);
    check("valid_cleared", {31'b0, o_instr_valid}, 32'd0);
    check("instr_kept", o_instr, m_instr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n      = 1'b0;
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h8C01_0004;
    i_retire     = 1'b0;
    i_is_jump    = 1'b0;
    i_is_branch  = 1'b0;
    i_alu_zero   = 1'b0;
    m_stall      = 0;
    m_retired    = 0;
    m_instr      = 32'h0;
    tick();
    tick();
    check("rst_req", {31'b0, o_imem_req}, 32'd0);
    check("rst_valid", {31'b0, o_instr_valid}, 32'd0);
    check("rst_instr", o_instr, 32'h0);
    check("rst_op_code", {26'b0, o_op_code}, 32'd0);
    check("rst_pc", o_pc, RESET_PC);
    check_counters("rst");

    // Ack held through release: ignored in the idle cycle, accepted on the first request cycle.
    i_rst_n = 1'b1;
    tick();
    check("idle_ack_ignored", {31'b0, o_instr_valid}, 32'd0);
    check("first_req", {31'b0, o_imem_req}, 32'd1);
    check("first_addr", o_imem_addr, 32'h0);
    tick();
    i_imem_ack = 1'b0;
    m_instr    = 32'h8C01_0004;
    check("first_valid", {31'b0, o_instr_valid}, 32'd1);
    check("first_pc", o_pc, 32'h0);
    check("first_op_code", {26'b0, o_op_code}, 32'h23);

    retire(1'b0, 1'b0, 1'b1, 32'h0000_0004);
    fetch(32'h0800_0004, 0);
    retire(1'b1, 1'b0, 1'b0, 32'h0000_0010);
    fetch(32'h0000_0020, 0);
    retire(1'b0, 1'b0, 1'b0, 32'h0000_0014);
    fetch(32'h0800_0040, 3);
    check_counters("delayed");
    retire(1'b1, 1'b0, 1'b0, 32'h0000_0100);
    fetch(32'h1022_FFFE, 0);
    retire(1'b0, 1'b1, 1'b1, 32'h0000_00FC);
    fetch(32'h1000_0000, 0);
    retire(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    fetch(32'h1022_FFFE, 0);
    retire(1'b0, 1'b1, 1'b0, 32'h0000_0104);
    fetch(32'h1000_FFFF, 0);
    retire(1'b0, 1'b1, 1'b1, 32'h0000_0104);
    fetch(32'h0800_0010, 0);
    retire(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    fetch(32'h1000_FFEE, 0);
    retire(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);

    // Retire while a request is outstanding is ignored.
    i_retire  = 1'b1;
    i_is_jump = 1'b1;
    tick();
    i_retire  = 1'b0;
    i_is_jump = 1'b0;
    m_stall++;
    check("retire_in_req_req", {31'b0, o_imem_req}, 32'd1);
    check("retire_in_req_pc", o_imem_addr, 32'hFFFF_FFFC);
    check("retire_in_req_valid", {31'b0, o_instr_valid}, 32'd0);
    fetch(32'h0000_0000, 0);

    // Ack while the instruction awaits retire is ignored.
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'hDEAD_BEEF;
    tick();
    i_imem_ack   = 1'b0;
    check("ack_in_valid_instr", o_instr, 32'h0000_0000);
    check("ack_in_valid_valid", {31'b0, o_instr_valid}, 32'd1);
    check("ack_in_valid_req", {31'b0, o_imem_req}, 32'd0);
    check("ack_in_valid_pc", o_pc, 32'hFFFF_FFFC);
    retire(1'b0, 1'b0, 1'b0, 32'h0000_0000);
    fetch(32'h2408_0001, 1);
    retire(1'b0, 1'b0, 1'b0, 32'h0000_0004);
    check_counters("pre_reset");

    // Asynchronous reset while a request is being acked.
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'hCAFE_F00D;
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'b0, o_imem_req}, 32'd0);
    check("async_rst_valid", {31'b0, o_instr_valid}, 32'd0);
    check("async_rst_instr", o_instr, 32'h0);
    check("async_rst_pc", o_pc, RESET_PC);
    m_stall   = 0;
    m_retired = 0;
    check_counters("async_rst");
    exp_addr_q.delete();
    tick();
    tick();
    i_imem_ack = 1'b0;
    i_rst_n    = 1'b1;
    exp_addr_q.push_back(RESET_PC);
    fetch(32'h8C01_0004, 0);
    check_counters("post_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
